// File: rtl/sobel_window_stream.sv
// sobel_window_stream: streaming 3x3 gradient filter for raster-order,
// multi-channel pixels. Each channel keeps two line buffers and a 3x3 window.
// A selectable kernel is applied to every complete window.
//
// Ports
//   clk, rst          clock and synchronous active-high reset
//   in_valid, in_sof  pixel strobe and start-of-frame (row 0, col 0)
//   mode              kernel select, taken on an accepted start-of-frame pixel:
//                     0 Gy, 1 Gx, 2 |Gx|+|Gy|, 3 centre passthrough
//   d_in              pixel; channel k sits in bits [(k+1)*DATA_W-1 : k*DATA_W]
//   out_valid, d_out  one-cycle result strobe and the filtered pixel (held)

// Per-channel slice: line buffers, window and kernel datapath.
module sobel_chan #(
    parameter int DATA_W = 4,
    parameter int IMG_W  = 16,
    parameter int COL_W  = $clog2(IMG_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              acc_i,
    input  logic [COL_W-1:0]  col_i,
    input  logic [DATA_W-1:0] pix_i,
    input  logic [1:0]        mode_i,
    output logic [DATA_W-1:0] res_o
);
    localparam int SW = DATA_W + 4;
    typedef logic signed [SW-1:0] s_t;
    localparam s_t MAXS = s_t'(2**DATA_W - 1);

    logic [DATA_W-1:0]            lb0_q [IMG_W];
    logic [DATA_W-1:0]            lb1_q [IMG_W];
    logic [2:0][2:0][DATA_W-1:0]  w_q;   // w_q[row][col], row 0 = oldest line

    // Line buffers carry no reset: their contents are only consumed once
    // two fresh lines of the current frame have overwritten them.
    always_ff @(posedge clk) begin
        if (acc_i) begin
            lb0_q[col_i] <= pix_i;
            lb1_q[col_i] <= lb0_q[col_i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_q <= '0;
        end else if (acc_i) begin
            for (int r = 0; r < 3; r++) begin
                w_q[r][0] <= w_q[r][1];
                w_q[r][1] <= w_q[r][2];
            end
            w_q[0][2] <= lb1_q[col_i];
            w_q[1][2] <= lb0_q[col_i];
            w_q[2][2] <= pix_i;
        end
    end

    function automatic s_t ext(input logic [DATA_W-1:0] p);
        return $signed({4'b0, p});
    endfunction

    function automatic logic [DATA_W-1:0] clamp(input s_t x);
        if (x < 0)         return '0;
        else if (x > MAXS) return MAXS[DATA_W-1:0];
        else               return x[DATA_W-1:0];
    endfunction

    s_t gy, gx, ax, ay, mag;

    always_comb begin
        gy  = (ext(w_q[2][0]) + (ext(w_q[2][1]) <<< 1) + ext(w_q[2][2]))
            - (ext(w_q[0][0]) + (ext(w_q[0][1]) <<< 1) + ext(w_q[0][2]));
        gx  = (ext(w_q[0][2]) + (ext(w_q[1][2]) <<< 1) + ext(w_q[2][2]))
            - (ext(w_q[0][0]) + (ext(w_q[1][0]) <<< 1) + ext(w_q[2][0]));
        ax  = (gx < 0) ? -gx : gx;
        ay  = (gy < 0) ? -gy : gy;
        mag = ax + ay;
        unique case (mode_i)
            2'd0:    res_o = clamp(gy);
            2'd1:    res_o = clamp(gx);
            2'd2:    res_o = clamp(mag);
            default: res_o = w_q[1][1];
        endcase
    end
endmodule

module sobel_window_stream #(
    parameter int DATA_W   = 4,
    parameter int CHANNELS = 3,
    parameter int IMG_W    = 16,
    parameter int COL_W    = $clog2(IMG_W)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic                       in_sof,
    input  logic [1:0]                 mode,
    input  logic [DATA_W*CHANNELS-1:0] d_in,
    output logic                       out_valid,
    output logic [DATA_W*CHANNELS-1:0] d_out
);
    localparam int STAGES = 1;

    logic [COL_W-1:0] col_q, col_d, col_eff;
    logic [1:0]       row_q, row_d, row_eff;
    logic [1:0]       mode_q, mode_d, mode_eff;
    logic [1:0]       mode_w_q;              // kernel for the window now held
    logic [STAGES:0]  vld_pipe_q;            // [0] window valid, [1] output valid
    logic             acc, win_vld;
    logic [CHANNELS-1:0][DATA_W-1:0] res;
    logic [DATA_W*CHANNELS-1:0]      d_out_q;

    // A start-of-frame pixel is itself row 0 / col 0 and already uses the
    // newly selected mode, so the effective values bypass the registers.
    always_comb begin
        acc      = in_valid & ~rst;
        col_eff  = in_sof ? '0 : col_q;
        row_eff  = in_sof ? '0 : row_q;
        mode_eff = in_sof ? mode : mode_q;
        win_vld  = acc && (row_eff == 2'd2) && (col_eff >= COL_W'(2));
        col_d    = col_q;
        row_d    = row_q;
        mode_d   = mode_q;
        if (acc) begin
            mode_d = mode_eff;
            if (col_eff == COL_W'(IMG_W - 1)) begin
                col_d = '0;
                row_d = (row_eff == 2'd2) ? 2'd2 : row_eff + 2'd1;
            end else begin
                col_d = col_eff + COL_W'(1);
                row_d = row_eff;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q      <= '0;
            row_q      <= '0;
            mode_q     <= '0;
            mode_w_q   <= '0;
            vld_pipe_q <= '0;
            d_out_q    <= '0;
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            mode_q     <= mode_d;
            vld_pipe_q <= {vld_pipe_q[STAGES-1:0], win_vld};
            if (acc)           mode_w_q <= mode_eff;
            if (vld_pipe_q[0]) d_out_q  <= res;
        end
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        sobel_chan #(.DATA_W(DATA_W), .IMG_W(IMG_W), .COL_W(COL_W)) u_ch (
            .clk    (clk),
            .rst    (rst),
            .acc_i  (acc),
            .col_i  (col_eff),
            .pix_i  (d_in[k*DATA_W +: DATA_W]),
            .mode_i (mode_w_q),
            .res_o  (res[k])
        );
    end

    assign out_valid = vld_pipe_q[STAGES];
    assign d_out     = d_out_q;
endmodule

// File: tb/tb_sobel_window_stream.sv
module tb_sobel_window_stream;
    localparam int DW = 4, CH = 3, W = 8;
    localparam int P_FLAT = 0, P_VRAMP = 1, P_HRAMP = 2, P_HREV = 3;

    logic             clk = 0, rst = 1, in_valid = 0, in_sof = 0;
    logic [1:0]       mode = 0;
    logic [DW*CH-1:0] d_in = 0;
    logic             out_valid;
    logic [DW*CH-1:0] d_out;

    int n_chk = 0, n_err = 0;
    logic [DW*CH-1:0] q [$];

    sobel_window_stream #(.DATA_W(DW), .CHANNELS(CH), .IMG_W(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof),
        .mode(mode), .d_in(d_in), .out_valid(out_valid), .d_out(d_out));

    always #5 clk = ~clk;

    always @(negedge clk) if (out_valid) q.push_back(d_out);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic px(input logic v, input logic sof, input logic [1:0] m, input logic [DW*CH-1:0] d);
        in_valid = v; in_sof = sof; mode = m; d_in = d;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) px(0, 0, 0, 0);
    endtask

    function automatic logic [DW*CH-1:0] pat(input int p, input int r, input int c);
        logic [3:0] a, b;
        a = 4'(r); b = 4'(2 * r);
        case (p)
            P_FLAT:  return 12'h555;
            P_VRAMP: return {4'h0, b, a};
            P_HRAMP: return {8'h00, 4'(c)};
            default: return {8'h00, 4'(7 - c)};
        endcase
    endfunction

    // Drain collected results: expect n pulses, all equal to val.
    task automatic check_q(input string tag, input int n, input logic [DW*CH-1:0] val);
        chk({tag, " count"}, q.size(), n);
        foreach (q[i]) chk({tag, " data"}, q[i], val);
        q.delete();
    endtask

    task automatic frame(input int p, input logic [1:0] m, input bit sof,
                         input int nrows, input bit gaps);
        int g0, g1, g2, idx;
        g0 = $urandom_range(3, 20); g1 = $urandom_range(21, 40); g2 = $urandom_range(41, 60);
        for (int r = 0; r < nrows; r++)
            for (int c = 0; c < W; c++) begin
                idx = r * W + c;
                if (gaps && (idx == g0 || idx == g1 || idx == g2))
                    for (int i = 0; i < 3; i++) begin
                        px(0, 0, 0, 0);
                        if (i > 0) chk("gap quiet", out_valid, 0);
                    end
                px(1, sof && idx == 0, m, pat(p, r, c));
            end
    endtask

    initial begin
        // reset and idle
        repeat (2) @(posedge clk);
        #1 rst = 0;
        chk("reset out_valid", out_valid, 0);
        chk("reset d_out", d_out, 0);
        for (int i = 0; i < 10; i++) begin
            idle(1);
            chk("idle out_valid", out_valid, 0);
            chk("idle d_out", d_out, 0);
        end
        q.delete();

        frame(P_FLAT, 0, 1, 8, 0);  idle(2); check_q("flat gy", 36, 12'h000);
        frame(P_FLAT, 3, 1, 8, 0);  idle(2); check_q("flat pass", 36, 12'h555);
        frame(P_VRAMP, 0, 1, 8, 0); idle(2); check_q("vramp gy", 36, 12'h0F8);
        frame(P_HRAMP, 1, 1, 8, 0); idle(2); check_q("hramp gx", 36, 12'h008);
        frame(P_HRAMP, 0, 1, 8, 0); idle(2); check_q("hramp gy", 36, 12'h000);
        frame(P_HRAMP, 2, 1, 8, 0); idle(2); check_q("hramp mag", 36, 12'h008);
        frame(P_HREV, 1, 1, 8, 0);  idle(2); check_q("hrev gx", 36, 12'h000);
        frame(P_HREV, 2, 1, 8, 0);  idle(2); check_q("hrev mag", 36, 12'h008);
        frame(P_VRAMP, 0, 1, 8, 1); idle(2); check_q("vramp gaps", 36, 12'h0F8);

        // restart mid-frame: new sof with Gx after four lines of a Gy frame
        frame(P_VRAMP, 0, 1, 4, 0);
        for (int k = 0; k < 8 * W; k++) begin
            px(1, k == 0, 1, pat(P_HRAMP, k / W, k % W));
            if (k == 0) begin
                chk("restart inflight valid", out_valid, 1);
                chk("restart inflight data", d_out, 12'h0F8);
            end else if (k <= 18) chk("restart quiet", out_valid, 0);
        end
        idle(2);
        chk("restart old count", q.size(), 48);
        for (int i = 0; i < q.size(); i++)
            chk(i < 12 ? "restart old data" : "restart new data", q[i], i < 12 ? 12'h0F8 : 12'h008);
        q.delete();

        // reset mid-frame: Gx frame cut at row 3, col 4
        frame(P_HRAMP, 1, 1, 3, 0);
        for (int c = 0; c < 4; c++) px(1, 0, 1, pat(P_HRAMP, 3, c));
        rst = 1;
        px(1, 0, 1, pat(P_HRAMP, 3, 4));
        rst = 0;
        chk("rst out_valid", out_valid, 0);
        chk("rst d_out", d_out, 0);
        check_q("pre-rst", 7, 12'h008);
        // sof without valid must not load mode 1
        px(0, 1, 1, 0);
        idle(1);
        frame(P_HRAMP, 1, 0, 8, 0); idle(2); check_q("post-rst mode0", 36, 12'h000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/sobel_window_stream.md
# sobel_window_stream

Streaming 3x3 gradient filter for raster-order multi-channel pixel data. Two internal line buffers build a full 3x3 window per channel at one pixel per valid cycle. The block applies a selectable kernel (Sobel Gy, Sobel Gx, |Gx|+|Gy|, or centre-pixel passthrough) and clamps each channel to the pixel range. It sits between the pixel source and the downstream edge/threshold stage, and replaces the fixed three-phase window buffer.

## Interface
- DATA_W, 4, bits per channel pixel, unsigned
- CHANNELS, 3, independent channels packed in d_in/d_out; channel k occupies bits [(k+1)*DATA_W-1 : k*DATA_W]
- IMG_W, 16, pixels per image line; must be >= 3
- COL_W, $clog2(IMG_W), column counter width

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  d_in carries a pixel this cycle
- in_sof  in  1  qualified by in_valid; marks the pixel at row 0, col 0
- mode  in  2  kernel select; sampled only on a pixel with in_valid=1 and in_sof=1
- d_in  in  DATA_W*CHANNELS  pixel, all channels
- out_valid  out  1  d_out holds a new result
- d_out  out  DATA_W*CHANNELS  filtered pixel, all channels

## Operation
- No backpressure. Every pixel with in_valid=1 is accepted. When in_valid=0, no counter, window or line-buffer state changes.
- Counters:
  - col runs 0..IMG_W-1, then wraps to 0 and increments row.
  - row saturates at 2; only row>=2 matters.
  - A pixel with in_sof=1 is treated as col=0,row=0; the counters then advance from there.
- Line buffers:
  - Two per channel, each IMG_W deep, indexed by col, read-before-write.
  - lb0 returns the pixel one line above; lb1 returns the pixel two lines above.
  - Neither is cleared on reset or on in_sof.
- Window:
  - w[r][c] per channel; r=0 is the top (oldest) row, c=0 is the left (oldest) column.
  - On each accepted pixel, columns shift left. The new column c=2 is {lb1 out, lb0 out, d_in}.
- A window is valid when the accepted pixel has row>=2 and col>=2. Its centre is at (row-1, col-1). Windows never span a line wrap.
- Kernels, per channel, signed internal width DATA_W+4:
  - Gy = (w20 + 2*w21 + w22) - (w00 + 2*w01 + w02)
  - Gx = (w02 + 2*w12 + w22) - (w00 + 2*w10 + w20)
- mode_r (reset 0) selects the output; MAX = 2^DATA_W-1:
  - mode 0: clamp(Gy)
  - mode 1: clamp(Gx)
  - mode 2: min(|Gx|+|Gy|, MAX)
  - mode 3: w11 unchanged
- clamp(x) = 0 if x<0; MAX if x>MAX; else x.
- mode_r is loaded when in_valid&in_sof. That pixel and all later pixels use the new mode.
- Reset clears: counters, window registers, mode_r, out_valid=0, d_out=0.

## Timing
- Latency is one cycle. An accepted pixel at edge t with a valid window gives out_valid=1 and the result on d_out after edge t+1.
- out_valid is high for exactly one cycle per valid window. It is 0 after any edge with no accepted pixel or with an invalid window.
- d_out holds its last value while out_valid=0.
- in_sof mid-frame:
  - The counters restart immediately.
  - out_valid stays 0 until row>=2 and col>=2 of the new frame.
  - Any in-flight result from the previous pixel still completes normally.
- rst mid-frame wins over in_valid in the same cycle. The pixel in that cycle is dropped.
- in_sof without in_valid is ignored.

## Test plan
- Reset then idle: after rst, out_valid=0 and d_out=0. Both stay 0 for 10 cycles with in_valid=0.
- Flat frame: IMG_W=8, 8 lines, all channels =5, mode 0 → exactly 36 out_valid pulses, each d_out=0. Repeat with mode 3 → every channel =5.
- Vertical ramp: ch0=row, ch1=2*row, ch2=0, mode 0 → for every valid window, ch0=8, ch1=15 (16 clamped), ch2=0.
- Horizontal ramp ch0=col, mode 1 → 8; same frame with mode 0 → 0, mode 2 → 8. Reversed ramp ch0=7-col: mode 1 → 0 (clamped -8), mode 2 → 8.
- Gaps: the vertical ramp frame with in_valid dropped for 3 cycles at random points → same output sequence as without gaps, with no out_valid during the gaps.
- Restart:
  - in_sof with mode=1 asserted at row 4, col 0 of a mode-0 frame → no out_valid for the next 18 accepted pixels; results thereafter use Gx.
  - rst asserted at row 3 → out_valid=0 on the next cycle and mode returns to 0.
